// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the fetch buffer entry type.
//   XLEN        - datapath / address width
//   INSTR_BYTES - PC increment per fetched instruction
//   fetch_entry_t - one buffered fetch: byte address plus instruction word
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch_entry_t.
//   clk, rst   - clock, async active-high reset
//   push/data  - write an entry (ignored when full)
//   pop        - drop the head entry (ignored when empty)
//   flush      - synchronous clear; wins over same-cycle push/pop
//   full/empty/count - occupancy
//   head       - current head entry (don't-care when empty)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push, w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointer wrap works for non-power-of-two depths too.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= nxt(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= nxt(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy tracking masks stale entries.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
//   clk, rst          - clock, async active-high reset
//   mem_req/mem_addr  - imem read strobe and byte address (1-cycle latency)
//   mem_rdata         - imem data, valid the cycle after mem_req
//   jump_en/jump_addr - redirect pulse and target (low 2 bits dropped)
//   out_valid/out_ready/out_instr/out_pc - buffered instruction to decode
//   fetch_pc          - next fetch address (debug)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] fetch_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_kill;

  logic            w_pop, w_push, w_full, w_empty, w_credit;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  fetch_entry_t    w_push_entry, w_head;
  logic            w_unused_jump_lsb;

  assign w_unused_jump_lsb = ^jump_addr[1:0];

  assign w_pop = out_valid & out_ready;

  // Occupancy including the word still in flight, less the word decode is
  // taking this cycle. A pop implies count >= 1, so this never underflows.
  assign w_occ    = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_credit = (w_occ < (CW+1)'(FIFO_DEPTH));

  // rst gates the combinational strobe so it drops the moment rst rises.
  assign mem_req  = ~rst & ~jump_en & w_credit;
  assign mem_addr = r_fetch_pc;
  assign fetch_pc = r_fetch_pc;

  assign w_push       = r_inflight & ~r_kill;
  assign w_push_entry = '{pc: r_inflight_pc, instr: mem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (jump_en),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (w_head)
  );

  assign out_valid = ~w_empty;
  assign out_instr = w_empty ? '0 : w_head.instr;
  assign out_pc    = w_empty ? '0 : w_head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
    end else if (jump_en) begin
      r_fetch_pc <= {jump_addr[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
    end else begin
      r_kill <= 1'b0;
      if (mem_req) begin
        r_fetch_pc    <= r_fetch_pc + XLEN'(INSTR_BYTES);
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  // Credit must keep a push from ever landing on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full && !w_pop && !jump_en));
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer sitting between the PC/instruction-memory datapath and decode. Owns the fetch PC, issues one read per cycle to a synchronous imem with fixed 1-cycle read latency, and buffers returned words in a small FIFO so decode can apply backpressure. Handles jump redirects by flushing queued and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries; minimum 2, which sustains 1 instr/cycle

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
mem_req  out  1  imem read strobe this cycle
mem_addr  out  32  imem byte address; equals fetch_pc
mem_rdata  in  32  imem data, valid the cycle after mem_req
jump_en  in  1  redirect request, single-cycle pulse
jump_addr  in  32  redirect target
out_valid  out  1  buffered instruction available
out_ready  in  1  decode accepts head entry
out_instr  out  32  head instruction
out_pc  out  32  byte address of out_instr
fetch_pc  out  32  next address to fetch (debug)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high. While rst=1: fetch_pc=RESET_PC, FIFO empty, inflight=0, kill=0, mem_req=0, out_valid=0, out_instr=0, out_pc=0.
- pop = out_valid & out_ready.
- Credit: mem_req = !jump_en & (count + inflight - pop < FIFO_DEPTH). The comparison is combinational.
- Issue: when mem_req=1, mem_addr=fetch_pc. On the edge: fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 0. Also set inflight=1 and inflight_pc=fetch_pc.
- When mem_req=0 in a cycle, inflight clears on the next edge.
- Response: in the cycle after an issue, if inflight=1 and kill=0, push {inflight_pc, mem_rdata} into the FIFO.
- Latency: request at cycle t, data pushed at end of t+1, out_valid visible at t+2.
- Throughput: 1 instr/cycle while out_ready=1.
- FIFO: out_valid = !empty. out_instr and out_pc come from the head entry. Push and pop in the same cycle keep count unchanged. Push when full cannot occur because credit prevents it; treat it as an assertion failure.
- Redirect: jump_en=1 in cycle t. Next edge:
  - fetch_pc = {jump_addr[31:2], 2'b00}; misaligned low bits are silently cleared.
  - FIFO is flushed, overriding any same-cycle push or pop.
  - If inflight=1, kill is set so the t+1 response is discarded.
  - mem_req=0 during cycle t. The first fetch from the new target is issued at t+1.
- Any pop asserted in the jump cycle still counts as a handshake from decode's view. Decode is responsible for ignoring it.
- Back-to-back jumps: the last one wins, and each one flushes.
- kill clears on the edge after it is consumed.
- Priority: rst > jump_en > push/pop.
- Reset asserted mid-operation: immediate return to reset values. No response from an in-flight request is pushed after rst deasserts.

Decomposition:
- fetch_pkg holds:
  - XLEN = 32
  - INSTR_BYTES = 4
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH. Ports: push, pop, flush, full, empty, count, head. Synchronous flush, async active-high reset.
- fetch_ctrl holds the PC, credit logic, inflight/kill tracking and redirect logic.

Test Plan:
- Imem model returns rdata = 32'hC0DE_0000 | addr[15:0] for all scenarios.
- Streaming: release rst, out_ready=1 held -> out_valid first high at cycle 2. Outputs (out_pc, out_instr) = (0x0, 0xC0DE0000), (0x4, 0xC0DE0004), (0x8, 0xC0DE0008), ... one per cycle with no bubbles.
- Backpressure: out_ready=0 from cycle 2 for 5 cycles -> mem_req drops once count + inflight = 2. fetch_pc holds at 0x8. No entry is lost or duplicated. After out_ready returns to 1, the sequence continues 0x0, 0x4, 0x8, ... in order.
- Redirect with in-flight fetch: while streaming, pulse jump_en with jump_addr=0x100 when fetch_pc=0x10 -> the 0x0C response is dropped and the FIFO is emptied. mem_req=0 in the jump cycle, then mem_addr=0x100. The next out_pc is 0x100 and no stale PC appears.
- Misaligned and wrap: jump_addr=0xFFFF_FFFE -> fetches 0xFFFF_FFFC, then 0x0000_0000. out_pc shows the same sequence.
- Reset mid-operation: assert rst asynchronously (between edges) with the FIFO full and inflight=1 -> out_valid=0 and mem_req=0 immediately, fetch_pc=RESET_PC. After release, the first out_pc is 0x0 and no pre-reset entry emerges.
- Back-to-back jumps: pulse jump_en for two consecutive cycles (targets 0x200, then 0x300) with out_ready=1 -> only the 0x300 stream appears, and no 0x200 entry is ever output.
